fifo_wr_rr_arbiter: RTL and testbench
=====================================

Name: fifo_wr_rr_arbiter

Overview:
Round-robin write-port arbiter that shares the single write port of the synchronous FIFO (wr_en/in_data/full) between NREQ producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write signals from the granted producer. It sits directly in front of the FIFO write side, and its FIFO-side ports connect to the FIFO's wr_en, in_data and full.

Parameters:
NREQ, 4, number of requesters (>=2)
DWIDTH, `DWIDTH, data word width (matches FIFO)
MAX_BURST, 4, max transfers per grant before forced rotation (>=1)
IDW, $clog2(NREQ), width of grant_id (derived, not overridable)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*DWIDTH  packed data; requester i at [i*DWIDTH +: DWIDTH]
req_ready  out  NREQ  per-requester accept; transfer when valid&ready
fifo_wr_en  out  1  FIFO write enable
fifo_in_data  out  DWIDTH  FIFO write data
fifo_full  in  1  FIFO full flag
grant_valid  out  1  a requester currently owns the port
grant_id  out  IDW  index of current owner

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State: fsm {ARB, GRANT}, owner[IDW-1:0], ptr[IDW-1:0] (RR start index), cnt (0..MAX_BURST-1).
- Reset (rst sampled high at posedge): fsm=ARB, owner=0, ptr=0, cnt=0.
- While rst is high, req_ready=0 and fifo_wr_en=0, forced combinationally and regardless of state.
- Outputs after reset: grant_valid=0, grant_id=0, fifo_in_data=0.
- ARB:
  - If no req_valid, stay in ARB.
  - Otherwise select the first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - Next cycle: owner=i, cnt=0, fsm=GRANT.
  - No transfer occurs in ARB. Grant latency is 1 cycle from valid.
- GRANT:
  - grant_valid=1, grant_id=owner.
  - req_ready[owner] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] & ~fifo_full (combinational, same cycle as the handshake).
  - fifo_in_data = req_data slice of owner.
- Transfer in GRANT (req_valid[owner] & ~fifo_full):
  - If cnt==MAX_BURST-1: release.
  - Else: cnt++.
- No transfer because fifo_full=1: hold owner and cnt, no release. Stays in GRANT indefinitely while full and the owner remains valid.
- req_valid[owner]=0 in GRANT: release, whether or not the FIFO is full.
- Release: fsm=ARB, ptr=owner+1 mod NREQ, cnt=0.
  - Exactly one ARB cycle separates bursts.
  - Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- grant_valid=0 and fifo_in_data=0 in ARB. grant_id holds the last owner in ARB.
- Never writes when fifo_full=1, so no FIFO overflow is possible from this block.
- Producers must hold req_data stable while valid&~ready. The bench checks this; the arbiter does not enforce it.
- Non-owner requesters never see ready. Dropping their valid has no effect.
- Reset mid-burst: no write in the reset cycle; next cycle fsm=ARB with ptr=0.
- ptr wrap: owner NREQ-1 releases to ptr=0.

Test Plan:
- rst=1 for 2 cycles with all req_valid=1 -> fifo_wr_en=0, req_ready=0, grant_valid=0 throughout; first grant to id 0 one cycle after rst drops.
- Only req 2 valid continuously, data 0x20,0x21,…, FIFO never full -> grant_id=2; writes 0x20..0x23 on 4 consecutive cycles, 1 idle cycle, then 0x24..0x27; 8 writes in 10 cycles after the first grant.
- All 4 reqs valid, each streaming its own tag (0xA0+n, 0xB0+n, …) -> FIFO receives 4 words from 0, then 1, 2, 3, then 0 again; in-order per requester; no word lost or duplicated.
- Req 1 granted; fifo_full=1 for 3 cycles after 2 transfers -> fifo_wr_en=0, req_ready[1]=0, grant_id stays 1; after full clears, exactly 2 more transfers, then release.
- Reqs 0 and 3 valid; req 0 drops valid after 1 transfer -> release after 1 word, next grant to 3 (ptr=1 skips invalid 1,2), and 3 gets a full 4-word burst.
- rst asserted on the 3rd transfer of req 1 -> no write that cycle; after rst drops with reqs 1 and 2 valid, the grant goes to 1 (ptr reset to 0, first valid ≥0).

Source files
------------

// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter
// Round-robin arbiter sharing one FIFO write port between NREQ valid/ready
// producers. A producer is granted for a burst of at most MAX_BURST words,
// then the grant rotates. One ARB cycle always separates two bursts.
//
// Ports:
//   i_clk           system clock, all state on posedge
//   i_rst           synchronous reset, active-high
//   i_req_valid     per-requester data valid
//   i_req_data      packed data, requester i at [i*DWIDTH +: DWIDTH]
//   o_req_ready     per-requester accept (transfer when valid & ready)
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_in_data  FIFO write data
//   i_fifo_full     FIFO full flag
//   o_grant_valid   a requester currently owns the port
//   o_grant_id      index of the current (or last) owner
module fifo_wr_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DWIDTH-1:0]   i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_fifo_wr_en,
  output logic [DWIDTH-1:0]        o_fifo_in_data,
  input  logic                     i_fifo_full,
  output logic                     o_grant_valid,
  output logic [IDW-1:0]           o_grant_id
);

  localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   w_owner_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_release;

  logic             w_pick_found;
  logic [IDW-1:0]   w_pick_id;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_idx;

  logic             w_owner_valid;
  logic [DWIDTH-1:0] w_owner_data;
  logic             w_in_grant;

  // Round-robin search: first valid requester starting at r_ptr, wrapping mod NREQ.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    w_sum        = '0;
    w_idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_pick_found && i_req_valid[w_idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = w_idx;
      end else begin
        w_pick_id    = w_pick_id;
      end
    end
  end

  // Mux out the current owner's valid bit and data word.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == IDW'(i)) begin
        w_owner_valid = i_req_valid[i];
        w_owner_data  = i_req_data[i*DWIDTH +: DWIDTH];
      end else begin
        w_owner_valid = w_owner_valid;
      end
    end
  end

  assign w_in_grant = (r_state == ST_GRANT);

  // Handshake and FIFO-side outputs; reset forces ready/write low at once.
  always_comb begin
    o_req_ready    = '0;
    o_fifo_wr_en   = 1'b0;
    o_fifo_in_data = '0;
    o_grant_valid  = w_in_grant;
    o_grant_id     = r_owner;
    if (w_in_grant) begin
      o_fifo_in_data = w_owner_data;
      if (!i_rst) begin
        o_req_ready[r_owner] = ~i_fifo_full;
        o_fifo_wr_en         = w_owner_valid & ~i_fifo_full;
      end else begin
        o_req_ready  = '0;
        o_fifo_wr_en = 1'b0;
      end
    end else begin
      o_fifo_in_data = '0;
    end
  end

  // Next-state: arbitration in ARB, burst counting and release in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_pick_found) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick_id;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_GRANT: begin
        // A dropped valid releases even while full; full alone only stalls.
        if (!w_owner_valid) begin
          w_release = 1'b1;
        end else if (!i_fifo_full) begin
          if (r_cnt == CNT_LAST) begin
            w_release = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
    if (w_release) begin
      w_state_nxt = ST_ARB;
      w_cnt_nxt   = '0;
      w_ptr_nxt   = (r_owner == ID_LAST) ? '0 : (r_owner + IDW'(1));
    end else begin
      w_ptr_nxt   = w_ptr_nxt;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ARB;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Testbench for fifo_wr_rr_arbiter: cycle-level reference model of the
// round-robin/burst rules plus directed scenarios with literal expectations.
module tb_fifo_wr_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_in_data;
  logic              fifo_full;
  logic              grant_valid;
  logic [1:0]        grant_id;

  fifo_wr_rr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_fifo_wr_en(fifo_wr_en),
    .o_fifo_in_data(fifo_in_data),
    .i_fifo_full(fifo_full),
    .o_grant_valid(grant_valid),
    .o_grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  int base [NREQ];
  int sent [NREQ];
  int wlog_d [$];
  int wlog_c [$];

  logic            s_gv;
  logic [1:0]      s_gid;
  logic            s_wr;
  logic [NREQ-1:0] s_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_left;

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_left <= MB;
    end else if (!m_busy) begin
      if (pick(m_ptr, req_valid) >= 0) begin
        m_busy <= 1'b1; m_owner <= pick(m_ptr, req_valid); m_left <= MB;
      end
    end else if (!req_valid[m_owner] || (!fifo_full && m_left == 1)) begin
      m_busy <= 1'b0; m_ptr <= (m_owner + 1) % NREQ;
    end else if (!fifo_full) begin
      m_left <= m_left - 1;
    end
  end

  logic [NREQ-1:0] e_ready;
  logic            e_wr;
  logic [DW-1:0]   e_data;

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_ready = '0;
      e_wr    = 1'b0;
      e_data  = '0;
      if (m_busy) begin
        e_data = req_data[m_owner*DW +: DW];
        if (!rst && !fifo_full) e_ready[m_owner] = 1'b1;
        e_wr = !rst && !fifo_full && req_valid[m_owner];
      end
      chk("grant_valid", grant_valid, m_busy);
      chk("grant_id", grant_id, m_owner);
      chk("req_ready", req_ready, e_ready);
      chk("fifo_wr_en", fifo_wr_en, e_wr);
      chk("fifo_in_data", fifo_in_data, e_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic upd_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(base[i] + sent[i]);
  endtask

  // One clock: sample at negedge (producer handshakes, write log), then
  // advance to just past the next posedge and present the next words.
  task automatic cycle();
    @(negedge clk);
    s_gv = grant_valid; s_gid = grant_id; s_wr = fifo_wr_en; s_ready = req_ready;
    for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) sent[i]++;
    if (fifo_wr_en) begin
      wlog_d.push_back(int'(fifo_in_data));
      wlog_c.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
    upd_data();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    wlog_d.delete(); wlog_c.delete();
    upd_data();
  endtask

  task automatic chk_log(input string nm, input int idx, input int d, input int c);
    if (idx >= wlog_d.size()) begin
      n_checks++; n_err++;
      $display("FAIL %s: write %0d missing, have %0d writes", nm, idx, wlog_d.size());
    end else begin
      chk({nm, "_data"}, wlog_d[idx], d);
      chk({nm, "_cycle"}, wlog_c[idx], c);
    end
  endtask

  int c0;
  int nwin;

  initial begin
    for (int i = 0; i < NREQ; i++) begin base[i] = 0; sent[i] = 0; end
    fifo_full = 1'b0;

    // 1) reset held two edges with all requesters valid
    base[0] = 'h01;
    rst = 1'b1; req_valid = 4'hF; upd_data();
    @(posedge clk); #1;
    chk_en = 1'b1;
    cycle();
    chk("rst_grant_valid", s_gv, 1'b0);
    chk("rst_req_ready", s_ready, 4'h0);
    chk("rst_wr_en", s_wr, 1'b0);
    rst = 1'b0;
    cycle();
    chk("first_arb_gv", s_gv, 1'b0);
    cycle();
    chk("first_grant_gv", s_gv, 1'b1);
    chk("first_grant_id", s_gid, 2'd0);
    chk("first_grant_wr", s_wr, 1'b1);

    // 2) single requester 2 streaming 0x20..
    do_reset();
    base[2] = 'h20; req_valid = 4'b0100; upd_data();
    c0 = cyc;
    repeat (12) cycle();
    for (int k = 0; k < 8; k++) chk_log("solo", k, 'h20 + k, c0 + 1 + k + ((k >= 4) ? 1 : 0));
    nwin = 0;
    foreach (wlog_c[j]) if (wlog_c[j] >= c0 + 1 && wlog_c[j] <= c0 + 10) nwin++;
    chk("solo_writes_in_10", nwin, 8);
    chk("solo_grant_id", s_gid, 2'd2);

    // 3) all four requesters with tags, rotation 0,1,2,3,0
    do_reset();
    base[0] = 'hA0; base[1] = 'hB0; base[2] = 'hC0; base[3] = 'hD0;
    req_valid = 4'hF; upd_data();
    c0 = cyc;
    repeat (22) cycle();
    chk("rr_write_count", wlog_d.size(), 17);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) chk_log("rr", r*4 + k, base[r] + k, c0 + 1 + r*5 + k);
    chk_log("rr_wrap", 16, 'hA4, c0 + 21);

    // 4) requester 1, FIFO full for 3 cycles after 2 transfers
    do_reset();
    base[1] = 'h10; req_valid = 4'b0010; upd_data();
    c0 = cyc;
    repeat (3) cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("full_wr_en", s_wr, 1'b0);
      chk("full_ready", s_ready, 4'h0);
      chk("full_grant_id", s_gid, 2'd1);
      chk("full_grant_valid", s_gv, 1'b1);
    end
    fifo_full = 1'b0;
    repeat (3) cycle();
    chk("full_release_gv", s_gv, 1'b0);
    chk("full_write_count", wlog_d.size(), 4);
    chk_log("full", 0, 'h10, c0 + 1);
    chk_log("full", 1, 'h11, c0 + 2);
    chk_log("full", 2, 'h12, c0 + 6);
    chk_log("full", 3, 'h13, c0 + 7);

    // 5) reqs 0 and 3; req 0 drops valid after one word
    do_reset();
    base[0] = 'h50; base[3] = 'h70; req_valid = 4'b1001; upd_data();
    c0 = cyc;
    repeat (2) cycle();
    req_valid = 4'b1000;
    repeat (7) cycle();
    chk("drop_release_gv", s_gv, 1'b0);
    chk("drop_write_count", wlog_d.size(), 5);
    chk_log("drop", 0, 'h50, c0 + 1);
    for (int k = 0; k < 4; k++) chk_log("drop_r3", 1 + k, 'h70 + k, c0 + 4 + k);

    // 6) reset on the third transfer of requester 1
    do_reset();
    base[1] = 'h30; req_valid = 4'b0010; upd_data();
    c0 = cyc;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_wr_en", s_wr, 1'b0);
    chk("midrst_write_count", wlog_d.size(), 2);
    rst = 1'b0; req_valid = 4'b0110;
    cycle();
    chk("midrst_arb_gv", s_gv, 1'b0);
    cycle();
    chk("midrst_grant_gv", s_gv, 1'b1);
    chk("midrst_grant_id", s_gid, 2'd1);
    chk_log("midrst", 2, 'h32, c0 + 5);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
